// File: rtl/regfile_multiread_if.sv
// rtl/regfile_multiread_if.sv - write/read request and registered read data bus of regfile_multiread
interface regfile_multiread_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic                           ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0]          ctrl_writeReg;
  logic [DATA_WIDTH-1:0]          data_writeReg;
  logic [NUM_READ-1:0]            rd_en;
  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg;
  logic [NUM_READ*DATA_WIDTH-1:0] data_readReg;
  logic [NUM_READ-1:0]            rd_valid;

  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg,
    output rd_en,
    output ctrl_readReg,
    input  data_readReg,
    input  rd_valid
  );

  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  data_writeReg,
    input  rd_en,
    input  ctrl_readReg,
    output data_readReg,
    output rd_valid
  );
endinterface

// File: rtl/regfile_multiread.sv
// rtl/regfile_multiread.sv - register file, one write port, NUM_READ registered read ports, r0 = 0
// Define REGFILE_BYPASS_EN to forward same-edge write data to colliding reads.
module regfile_multiread #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input logic                clock,
  input logic                ctrl_reset,
  regfile_multiread_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]          regs_q  [NUM_REGS];
  logic [DATA_WIDTH-1:0]          regs_d  [NUM_REGS];
  logic [DATA_WIDTH-1:0]          rdata_q [NUM_READ];
  logic [DATA_WIDTH-1:0]          rdata_d [NUM_READ];
  logic [NUM_READ-1:0]            rd_valid_q;
  logic [NUM_READ-1:0]            rd_valid_d;
  logic [ADDR_WIDTH-1:0]          rd_addr [NUM_READ];
  logic [DATA_WIDTH-1:0]          rd_sel  [NUM_READ];
  logic [NUM_READ-1:0]            rd_fwd;
  logic [NUM_READ*DATA_WIDTH-1:0] rdata_packed;
  logic                           wr_hit;

  // Writes to r0 are dropped here, so regs_q[0] never leaves its reset value.
  assign wr_hit = bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (wr_hit) begin
      regs_d[bus.ctrl_writeReg] = bus.data_writeReg;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      rd_addr[p] = bus.ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
      rd_fwd[p]  = wr_hit && (bus.ctrl_writeReg == rd_addr[p]);
`else
      rd_fwd[p]  = 1'b0;
`endif
      if (rd_addr[p] == '0) begin
        rd_sel[p] = '0;
      end else if (rd_fwd[p]) begin
        rd_sel[p] = bus.data_writeReg;
      end else begin
        rd_sel[p] = regs_q[rd_addr[p]];
      end
    end
  end

  // Idle ports keep their last data; only the valid flag drops.
  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      rdata_d[p] = bus.rd_en[p] ? rd_sel[p] : rdata_q[p];
    end
    rd_valid_d = bus.rd_en;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      for (int p = 0; p < NUM_READ; p++) begin
        rdata_q[p] <= '0;
      end
      rd_valid_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      for (int p = 0; p < NUM_READ; p++) begin
        rdata_q[p] <= rdata_d[p];
      end
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    rdata_packed = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      rdata_packed[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
    end
  end

  assign bus.data_readReg = rdata_packed;
  assign bus.rd_valid     = rd_valid_q;
endmodule

// File: doc/regfile_multiread.md
Name: regfile_multiread

Overview:
- Parametrised register file with one write port and NUM_READ independent registered read ports.
- Read data is registered with 1-cycle latency and a per-port valid flag; register 0 is hardwired to zero.
- Successor to the single combinational decode/tristate read port. Replaces the per-register tristate selection with a mux plus an output register.
- Sits between decode (register addresses) and the execute pipeline register in the processor datapath.

Parameters:
- DATA_WIDTH, 32, width of each register and of each read/write data bus.
- ADDR_WIDTH, 5, register address width; the file holds 2**ADDR_WIDTH registers.
- NUM_READ, 2, number of read ports (1..4).

Ports:
- clock  input  1  rising-edge clock.
- ctrl_reset  input  1  asynchronous, active-low reset (low = reset asserted).
- ctrl_writeEnable  input  1  write strobe, sampled on the rising edge.
- ctrl_writeReg  input  ADDR_WIDTH  write address.
- data_writeReg  input  DATA_WIDTH  write data.
- rd_en  input  NUM_READ  per-port read request; bit i belongs to port i.
- ctrl_readReg  input  NUM_READ*ADDR_WIDTH  packed read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- data_readReg  output  NUM_READ*DATA_WIDTH  packed registered read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- rd_valid  output  NUM_READ  per-port flag: data_readReg slice i holds the result of a request made the previous cycle.

Behaviour:
- Reset:
  - ctrl_reset low clears every register, every data_readReg slice and every rd_valid bit to 0 immediately, without waiting for a clock edge.
  - This applies mid-operation too: reset overrides everything, and in-flight reads are discarded.
  - The first edge after ctrl_reset rises behaves normally.
- Write:
  - On a rising edge with ctrl_writeEnable=1 and ctrl_writeReg!=0, the addressed register takes data_writeReg.
  - Writes to address 0 are discarded; register 0 always reads 0.
- Read, per port i, independently:
  - On a rising edge with rd_en[i]=1, the output slice i loads the selected register value and rd_valid[i] is set to 1.
  - Latency is exactly 1 cycle: data requested at edge N is visible after edge N.
  - On a rising edge with rd_en[i]=0, output slice i holds its previous value and rd_valid[i] clears to 0.
- Address 0 on any read port returns 0, regardless of any write to address 0 in the same cycle.
- Simultaneous access:
  - Several ports may read the same address in one cycle; all return the same value.
  - Read/write same-address collisions follow the optional-feature rule below.
- Address range: all 2**ADDR_WIDTH addresses are legal; there is no wrap-around.
- Implementation: storage and output registers are flip-flops; read-side address decode is a mux. No tristate buffers anywhere.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read bypass. On an edge where port i reads the nonzero address being written that same edge, output slice i loads data_writeReg (the new value).
- Undefined: the same collision returns the old register contents. The new value is visible only to reads issued on later edges.
- Either way, address 0 returns 0.

Test Plan:
- Reset: hold ctrl_reset low, then release; issue rd_en=2'b11 with addresses 5 and 31 -> next cycle both slices read 0x00000000 and rd_valid=2'b11.
- Write then read: write 0xDEADBEEF to r7; next edge read r7 on port 0 and r0 on port 1 -> port0=0xDEADBEEF, port1=0x00000000, rd_valid=2'b11.
- r0 protection: write 0x12345678 to r0, then read r0 on both ports -> both 0x00000000.
- Hold: read r7 (0xDEADBEEF) on port 0, then drop rd_en[0] for 3 cycles while r7 is rewritten to 0x1 -> data holds 0xDEADBEEF and rd_valid[0]=0; the next read returns 0x00000001.
- Collision: r3=0xA, then on the same edge write 0xB to r3 and read r3 on port 1 -> returns 0xB with REGFILE_BYPASS_EN defined, 0xA without it; a read on the following edge returns 0xB in both builds.
- Mid-operation reset: pulse ctrl_reset low for half a cycle between edges while rd_valid=2'b11 -> outputs, rd_valid and all registers go to 0 immediately; a read of r7 afterwards returns 0.
